fp_add_arbiter: RTL and testbench
=================================

# fp_add_arbiter

Round-robin arbiter that shares one pipelined `floating_point_add` instance among `NUM_REQ` requesters. Each accepted operand pair is issued to the adder with its requester ID tagged in a delay line matching the adder latency. Each result is routed back to the requester that issued it. The block sits between the accelerator's compute lanes and the single adder, and gives each lane a valid/ready request port and a valid-only response port.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `ADD_LATENCY`, 4, adder latency in cycles from `validIn` to `validOut`; must match the instantiated adder
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester ID tag (derived, not overridden)

Ports:
- `clkIn`  in  1  single clock; all logic on the rising edge
- `rstIn`  in  1  synchronous, active-low reset
- `reqValidIn`  in  NUM_REQ  per-requester request valid
- `reqDataAIn`  in  32*NUM_REQ  operand A, IEEE-754 single; requester i occupies bits [32i+31:32i]
- `reqDataBIn`  in  32*NUM_REQ  operand B, same packing as `reqDataAIn`
- `reqReadyOut`  out  NUM_REQ  one-hot grant; combinational from the valids and the round-robin pointer
- `addDataAOut`  out  32  registered operand A to the adder `dataAIn`
- `addDataBOut`  out  32  registered operand B to the adder `dataBIn`
- `addValidOut`  out  1  registered valid to the adder `validIn`
- `addDataIn`  in  32  adder `dataOut`
- `addValidIn`  in  1  adder `validOut`
- `rspDataOut`  out  32  registered sum, broadcast to all requesters
- `rspValidOut`  out  NUM_REQ  registered one-hot response valid
- `busyOut`  out  1  high while any operation is in flight
- `errorOut`  out  1  sticky tag/result mismatch flag

## Operation
- **Arbitration.** Each cycle, grant the first requester with `reqValidIn` high, searching from `rrPtr` upward with wrap (`rrPtr`, `rrPtr`+1, …, `NUM_REQ`-1, 0, …).
  - At most one bit of `reqReadyOut` is high.
  - A transfer occurs when both valid and ready are high for that requester.
- **Pointer update.** On a transfer from requester g, `rrPtr` <= (g+1) mod `NUM_REQ`. With no transfer, `rrPtr` holds.
- **Issue register.** On a transfer:
  - `addDataAOut`/`addDataBOut` capture the granted operands.
  - `addValidOut` <= 1 and `issueId` <= g.
  - Otherwise `addValidOut` <= 0 and the data registers hold.
- **Tag pipeline.** `ADD_LATENCY` stages of {valid, ID}, shifted every cycle.
  - Stage 0 loads {`addValidOut`, `issueId`}.
  - The final stage is aligned with `addValidIn`.
- **Response.** When `addValidIn` and the tail valid are both high:
  - `rspDataOut` <= `addDataIn`.
  - `rspValidOut` <= one-hot(tail ID).
  - Otherwise `rspValidOut` <= 0 and `rspDataOut` holds.
- **No response backpressure.** Requesters must accept responses in the cycle `rspValidOut` is high.
- **Error.** `errorOut` <= 1 when `addValidIn` differs from the tail valid. It stays set until reset. A result with no tag is dropped.
- **Busy.** `busyOut` = `addValidOut` OR any tag-stage valid OR any `rspValidOut` bit.

## Timing
- **Throughput.** One issue per cycle, sustained.
- **Latency.** Accept at cycle t gives:
  - `addValidOut` at t+1
  - `addValidIn` at t+1+`ADD_LATENCY`
  - `rspValidOut` at t+2+`ADD_LATENCY` (6 cycles at default)
- **Ordering.** Responses return in issue order. No reordering.
- **Reset values** (while `rstIn` = 0, effective at the next edge):
  - `rrPtr` = 0; all tag valids = 0
  - `addValidOut` = 0, `addDataAOut` = 0, `addDataBOut` = 0
  - `rspValidOut` = 0, `rspDataOut` = 0
  - `errorOut` = 0, `busyOut` = 0
  - `reqReadyOut` is forced to 0 combinationally while `rstIn` = 0
- **Reset mid-operation.** All in-flight tags are discarded.
  - The adder shares `rstIn`, so no stray results are expected.
  - A stray `addValidIn` after reset sets `errorOut`.
- **All requesters valid continuously.** Grants rotate 0,1,2,3,0,…; the starvation bound is `NUM_REQ`-1 cycles.
- **Requester drops valid with no transfer.** No state change; the pointer does not advance.
- **Single requester.** Granted every cycle regardless of `rrPtr` position.

## Test plan
- **Single request.** Reset low 10 cycles, then high. Requester 2 presents A=0x3F800000 (1.0), B=0x40000000 (2.0) for one cycle.
  - `reqReadyOut`=4'b0100 in the same cycle.
  - 6 cycles later: `rspValidOut`=4'b0100, `rspDataOut`=0x40400000 (3.0).
  - `busyOut` falls the following cycle.
- **Full contention.** All 4 requesters valid for 8 cycles, requester i sending A=i+1 (float), B=1.0.
  - Grant sequence 0,1,2,3,0,1,2,3.
  - Responses in the same order with sums 2.0, 3.0, 4.0, 5.0, repeating.
  - `rspValidOut` high on 8 consecutive cycles.
- **Pointer wrap and skip.** After a grant to requester 3, only requesters 1 and 3 are valid.
  - Grant 1, then 3, then 1.
  - Response IDs match the issue IDs.
- **Back-to-back from one requester.** Requester 0 sends (1.5, 1.0) then (2.5, 1.5) on consecutive cycles.
  - Responses 0x40200000 then 0x40800000 on consecutive cycles, both to requester 0.
- **Reset mid-flight.** Issue 3 requests, then pull `rstIn` low for 1 cycle, 2 cycles after the last issue.
  - No `rspValidOut` after reset.
  - `busyOut`=0 and `errorOut`=0.
- **Spurious result.** Force `addValidIn`=1 with an empty tag pipeline.
  - `errorOut` goes high the next cycle and stays high.
  - No `rspValidOut` bit asserts.
  - Reset clears `errorOut`.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin front end that shares one pipelined float adder
// among NUM_REQ requesters, tagging each issue with its requester ID so the
// result can be steered back to the lane that asked for it.
module fp_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 4
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic [NUM_REQ-1:0]    reqValidIn,
    input  logic [32*NUM_REQ-1:0] reqDataAIn,
    input  logic [32*NUM_REQ-1:0] reqDataBIn,
    output logic [NUM_REQ-1:0]    reqReadyOut,
    output logic [31:0]           addDataAOut,
    output logic [31:0]           addDataBOut,
    output logic                  addValidOut,
    input  logic [31:0]           addDataIn,
    input  logic                  addValidIn,
    output logic [31:0]           rspDataOut,
    output logic [NUM_REQ-1:0]    rspValidOut,
    output logic                  busyOut,
    output logic                  errorOut
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   add_valid_q, add_valid_d;
    logic [31:0]            add_data_a_q, add_data_a_d;
    logic [31:0]            add_data_b_q, add_data_b_d;
    logic [ID_W-1:0]        issue_id_q, issue_id_d;
    logic [ADD_LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [ID_W-1:0]        tag_id_q [ADD_LATENCY];
    logic [ID_W-1:0]        tag_id_d [ADD_LATENCY];
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                   error_q, error_d;

    logic [NUM_REQ-1:0]     grant_vec;
    logic [ID_W-1:0]        grant_id;
    logic                   transfer;
    logic                   tail_valid;
    logic [ID_W-1:0]        tail_id;

    // Search upward from the pointer with wrap; first valid requester wins, nobody during reset.
    always_comb begin
        int  idx;
        logic found;
        grant_vec = '0;
        grant_id  = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && reqValidIn[idx]) begin
                found          = 1'b1;
                grant_vec[idx] = 1'b1;
                grant_id       = ID_W'(idx);
            end
        end
        if (!rstIn) begin
            grant_vec = '0;
            grant_id  = '0;
        end
    end

    assign reqReadyOut = grant_vec;
    assign transfer    = |(grant_vec & reqValidIn);
    assign tail_valid  = tag_valid_q[ADD_LATENCY-1];
    assign tail_id     = tag_id_q[ADD_LATENCY-1];

    // Next state: pointer advance, issue register, tag shift, response steering and sticky error.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        add_valid_d  = transfer;
        add_data_a_d = add_data_a_q;
        add_data_b_d = add_data_b_q;
        issue_id_d   = issue_id_q;
        if (transfer) begin
            rr_ptr_d   = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
            issue_id_d = grant_id;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_vec[i]) begin
                    add_data_a_d = reqDataAIn[32*i +: 32];
                    add_data_b_d = reqDataBIn[32*i +: 32];
                end
            end
        end

        tag_valid_d[0] = add_valid_q;
        tag_id_d[0]    = issue_id_q;
        for (int s = 1; s < ADD_LATENCY; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_id_d[s]    = tag_id_q[s-1];
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (addValidIn && tail_valid) begin
            rsp_data_d = addDataIn;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tail_id == ID_W'(i));
            end
        end

        error_d = error_q | (addValidIn != tail_valid);
    end

    // State registers with synchronous active-low reset; in-flight tags are dropped on reset.
    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            rr_ptr_q     <= '0;
            add_valid_q  <= 1'b0;
            add_data_a_q <= '0;
            add_data_b_q <= '0;
            issue_id_q   <= '0;
            tag_valid_q  <= '0;
            for (int s = 0; s < ADD_LATENCY; s++) tag_id_q[s] <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            add_valid_q  <= add_valid_d;
            add_data_a_q <= add_data_a_d;
            add_data_b_q <= add_data_b_d;
            issue_id_q   <= issue_id_d;
            tag_valid_q  <= tag_valid_d;
            for (int s = 0; s < ADD_LATENCY; s++) tag_id_q[s] <= tag_id_d[s];
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            error_q      <= error_d;
        end
    end

    assign addValidOut = add_valid_q;
    assign addDataAOut = add_data_a_q;
    assign addDataBOut = add_data_b_q;
    assign rspDataOut  = rsp_data_q;
    assign rspValidOut = rsp_valid_q;
    assign errorOut    = error_q;
    assign busyOut     = add_valid_q | (|tag_valid_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: behavioural adder plus a transaction-history
// reference model of arbitration, latency, busy and error behaviour.
module tb_fp_add_arbiter;

    localparam int N = 4;
    localparam int L = 4;

    logic            clkIn = 1'b0;
    logic            rstIn;
    logic [N-1:0]    reqValidIn;
    logic [32*N-1:0] reqDataAIn;
    logic [32*N-1:0] reqDataBIn;
    logic [N-1:0]    reqReadyOut;
    logic [31:0]     addDataAOut;
    logic [31:0]     addDataBOut;
    logic            addValidOut;
    logic [31:0]     addDataIn;
    logic            addValidIn;
    logic [31:0]     rspDataOut;
    logic [N-1:0]    rspValidOut;
    logic            busyOut;
    logic            errorOut;

    logic            force_v = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        int          issue_cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } txn_t;

    txn_t hist[$];
    int   cyc   = 0;
    int   ptr   = 0;
    logic err_m = 1'b0;

    fp_add_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L)) dut (
        .clkIn(clkIn), .rstIn(rstIn),
        .reqValidIn(reqValidIn), .reqDataAIn(reqDataAIn), .reqDataBIn(reqDataBIn),
        .reqReadyOut(reqReadyOut),
        .addDataAOut(addDataAOut), .addDataBOut(addDataBOut), .addValidOut(addValidOut),
        .addDataIn(addDataIn), .addValidIn(addValidIn),
        .rspDataOut(rspDataOut), .rspValidOut(rspValidOut),
        .busyOut(busyOut), .errorOut(errorOut)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clkIn = ~clkIn;

    function automatic real sp2r(logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        m = real'({1'b1, x[22:0]});
        e = int'(x[30:23]) - 150;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(real r);
        real         m;
        int          e;
        logic        s;
        logic [7:0]  eb;
        logic [22:0] f;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        eb = 8'(e);
        f  = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, eb, f};
    endfunction

    logic [L-1:0] av_q;
    logic [31:0]  ad_q [L];

    // Behavioural pipelined adder sharing the arbiter reset; force_v injects a stray result.
    always @(posedge clkIn) begin
        if (!rstIn) begin
            av_q <= '0;
            for (int i = 0; i < L; i++) ad_q[i] <= '0;
        end else begin
            av_q    <= {av_q[L-2:0], addValidOut};
            ad_q[0] <= r2sp(sp2r(addDataAOut) + sp2r(addDataBOut));
            for (int i = 1; i < L; i++) ad_q[i] <= ad_q[i-1];
        end
    end

    assign addValidIn = av_q[L-1] | force_v;
    assign addDataIn  = ad_q[L-1];

    task automatic checkNow(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int predictGrant(logic [N-1:0] v, logic rst);
        if (!rst) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input int g);
        logic        exp_av = 1'b0;
        logic [31:0] exp_a  = '0;
        logic [31:0] exp_b  = '0;
        logic [N-1:0] exp_rv = '0;
        logic [31:0] exp_rd = '0;
        logic        exp_busy = 1'b0;
        foreach (hist[j]) begin
            if (hist[j].issue_cyc == cyc - 1) begin
                exp_av = 1'b1; exp_a = hist[j].a; exp_b = hist[j].b;
            end
            if (hist[j].issue_cyc + L + 2 == cyc) begin
                exp_rv = N'(1) << hist[j].id; exp_rd = hist[j].sum;
            end
            if (hist[j].issue_cyc < cyc && cyc <= hist[j].issue_cyc + L + 2) exp_busy = 1'b1;
        end
        checkNow("ready", 32'(reqReadyOut), (g >= 0) ? (32'd1 << g) : 32'd0);
        checkNow("add_valid", 32'(addValidOut), 32'(exp_av));
        if (exp_av) begin
            checkNow("add_a", addDataAOut, exp_a);
            checkNow("add_b", addDataBOut, exp_b);
        end
        checkNow("rsp_valid", 32'(rspValidOut), 32'(exp_rv));
        if (exp_rv != '0) checkNow("rsp_data", rspDataOut, exp_rd);
        checkNow("busy", 32'(busyOut), 32'(exp_busy));
        checkNow("error", 32'(errorOut), 32'(err_m));
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [32*N-1:0] a,
                                 input logic [32*N-1:0] b, input logic rst);
        int   g;
        logic tail;
        txn_t t;
        reqValidIn = v;
        reqDataAIn = a;
        reqDataBIn = b;
        rstIn      = rst;
        #1;
        g = predictGrant(v, rst);
        checkOutput(g);
        @(posedge clkIn);
        if (!rst) begin
            hist.delete();
            ptr   = 0;
            err_m = 1'b0;
        end else begin
            tail = 1'b0;
            foreach (hist[j]) if (hist[j].issue_cyc + L + 1 == cyc) tail = 1'b1;
            if ((tail | force_v) != tail) err_m = 1'b1;
            if (g >= 0) begin
                t.id = g; t.issue_cyc = cyc;
                t.a = a[32*g +: 32]; t.b = b[32*g +: 32];
                t.sum = r2sp(sp2r(t.a) + sp2r(t.b));
                hist.push_back(t);
                ptr = (g + 1) % N;
            end
        end
        cyc++;
        while (hist.size() > 0 && hist[0].issue_cyc + L + 2 < cyc) void'(hist.pop_front());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, 1'b1);
    endtask

    function automatic logic [31:0] rndOp();
        return r2sp(real'($urandom_range(1, 1023)) / 4.0);
    endfunction

    initial begin
        logic [32*N-1:0] a, b;
        logic [N-1:0]    v;

        rstIn = 1'b0; reqValidIn = '0; reqDataAIn = '0; reqDataBIn = '0;
        repeat (2) @(posedge clkIn);
        #1;
        for (int i = 0; i < 8; i++) applyStimulus('0, '0, '0, 1'b0);
        idle(2);

        $display("[TB] single request");
        a = '0; b = '0;
        a[64 +: 32] = 32'h3F800000;
        b[64 +: 32] = 32'h40000000;
        reqValidIn = 4'b0100; reqDataAIn = a; reqDataBIn = b; #1;
        checkNow("single_ready", 32'(reqReadyOut), 32'b0100);
        applyStimulus(4'b0100, a, b, 1'b1);
        idle(5);
        reqValidIn = '0; #1;
        checkNow("single_rsp_valid", 32'(rspValidOut), 32'b0100);
        checkNow("single_rsp_data", rspDataOut, 32'h40400000);
        idle(1);
        checkNow("single_busy_fall", 32'(busyOut), 32'd0);
        idle(2);

        $display("[TB] full contention");
        for (int i = 0; i < N; i++) begin
            a[32*i +: 32] = r2sp(real'(i + 1));
            b[32*i +: 32] = 32'h3F800000;
        end
        for (int i = 0; i < 8; i++) applyStimulus(4'b1111, a, b, 1'b1);
        idle(8);

        $display("[TB] pointer wrap and skip");
        applyStimulus(4'b1000, a, b, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'b1010, a, b, 1'b1);
        idle(8);

        $display("[TB] back-to-back requester 0");
        a[0 +: 32] = 32'h3FC00000; b[0 +: 32] = 32'h3F800000;
        applyStimulus(4'b0001, a, b, 1'b1);
        a[0 +: 32] = 32'h40200000; b[0 +: 32] = 32'h3FC00000;
        applyStimulus(4'b0001, a, b, 1'b1);
        idle(4);
        reqValidIn = '0; #1;
        checkNow("b2b_first", rspDataOut, 32'h40200000);
        idle(1);
        checkNow("b2b_second", rspDataOut, 32'h40800000);
        checkNow("b2b_second_id", 32'(rspValidOut), 32'b0001);
        idle(4);

        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                a[32*i +: 32] = rndOp();
                b[32*i +: 32] = rndOp();
            end
            v = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
            applyStimulus(v, a, b, 1'b1);
        end
        idle(8);

        $display("[TB] reset mid-flight");
        applyStimulus(4'b0001, a, b, 1'b1);
        applyStimulus(4'b0010, a, b, 1'b1);
        applyStimulus(4'b0100, a, b, 1'b1);
        idle(1);
        applyStimulus(4'b1111, a, b, 1'b0);
        idle(8);
        checkNow("reset_busy", 32'(busyOut), 32'd0);
        checkNow("reset_error", 32'(errorOut), 32'd0);

        $display("[TB] spurious result");
        force_v = 1'b1;
        idle(1);
        force_v = 1'b0;
        checkNow("spur_error_set", 32'(errorOut), 32'd1);
        idle(4);
        checkNow("spur_error_sticky", 32'(errorOut), 32'd1);
        checkNow("spur_no_rsp", 32'(rspValidOut), 32'd0);
        applyStimulus('0, '0, '0, 1'b0);
        checkNow("spur_error_clear", 32'(errorOut), 32'd0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
